uart_frame_checksum: RTL and testbench

Parametrised UART frame checksum engine for the serial test path. It sits between the UART receiver/transmitter handshake signals and the board debug outputs. It accumulates a checksum, XOR or modular sum, over terminator-delimited frames. It then transmits the checksum and, optionally, the frame length back over the UART. Compared with the first-generation loopback checker, it adds:
- configurable data width, terminator and checksum mode;
- bounded frame length with overflow handling;
- a robust two-phase transmit handshake;
- frame counting.

---
 rtl/uart_frame_checksum.sv | 195 +++++++++++++++++++
 tb/tb_uart_frame_checksum.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_checksum.sv
// UART frame checksum engine: accumulates XOR/additive checksum over
// terminator-delimited frames and sends checksum (and length) back.
module uart_frame_checksum #(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] TERM     = '0,
  parameter int                MODE     = 0,
  parameter int                MAX_LEN  = 255,
  parameter int                LEN_W    = 8,
  parameter int                SEND_LEN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic              rx_enable,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] checksum,
  output logic [7:0]        frame_count,
  output logic              overflow,
  output logic [2:0]        state_o
);

  localparam logic [2:0] RECV        = 3'd0;
  localparam logic [2:0] SUM_START   = 3'd1;
  localparam logic [2:0] SUM_WAIT_HI = 3'd2;
  localparam logic [2:0] SUM_WAIT_LO = 3'd3;
  localparam logic [2:0] LEN_START   = 3'd4;
  localparam logic [2:0] LEN_WAIT_HI = 3'd5;
  localparam logic [2:0] LEN_WAIT_LO = 3'd6;

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam int MW = (DATA_W > LEN_W) ? DATA_W : LEN_W;

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_nx;
  logic [LEN_W-1:0]  len;
  logic [MW-1:0]     len_wide;
  logic [DATA_W-1:0] len_word;
  logic              accept;
  logic              close;
  logic              drop;
  logic              load_len;
  logic              done;
  logic              is_term;
  logic              room;

  assign checksum = acc;
  assign state_o  = state;
  assign is_term  = (rx_data == TERM);
  assign room     = (len < MAX_L);

  // length word is the counter zero-extended or truncated to DATA_W
  assign len_wide = MW'(len);
  assign len_word = len_wide[DATA_W-1:0];

  // checksum update for one accepted character
  always_comb begin
    acc_nx = acc;
    if (MODE != 0) begin
      acc_nx = acc + rx_data;
    end else begin
      acc_nx = acc ^ rx_data;
    end
  end

  // next-state and per-cycle control decode
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    close    = 1'b0;
    drop     = 1'b0;
    load_len = 1'b0;
    done     = 1'b0;
    case (state)
      RECV: begin
        if (rx_ready) begin
          if (is_term) begin
            close    = 1'b1;
            state_nx = SUM_START;
          end else if (room) begin
            accept   = 1'b1;
          end else begin
            drop     = 1'b1;
            state_nx = SUM_START;
          end
        end
      end
      SUM_START: begin
        state_nx = SUM_WAIT_HI;
      end
      SUM_WAIT_HI: begin
        if (tx_busy) begin
          state_nx = SUM_WAIT_LO;
        end
      end
      SUM_WAIT_LO: begin
        if (!tx_busy) begin
          if (SEND_LEN != 0) begin
            load_len = 1'b1;
            state_nx = LEN_START;
          end else begin
            done     = 1'b1;
            state_nx = RECV;
          end
        end
      end
      LEN_START: begin
        state_nx = LEN_WAIT_HI;
      end
      LEN_WAIT_HI: begin
        if (tx_busy) begin
          state_nx = LEN_WAIT_LO;
        end
      end
      LEN_WAIT_LO: begin
        if (!tx_busy) begin
          done     = 1'b1;
          state_nx = RECV;
        end
      end
      default: begin
        state_nx = RECV;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RECV;
    end else begin
      state <= state_nx;
    end
  end

  // accumulator and length counter; cleared on frame completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      len <= '0;
    end else if (done) begin
      acc <= '0;
      len <= '0;
    end else if (accept) begin
      acc <= acc_nx;
      len <= len + 1'b1;
    end
  end

  // transmit word: checksum at frame end, length after checksum sent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data <= '0;
    end else if (close || drop) begin
      tx_data <= acc;
    end else if (load_len) begin
      tx_data <= len_word;
    end
  end

  // registered strobes so they line up with the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start  <= 1'b0;
      rx_enable <= 1'b0;
    end else begin
      tx_start  <= (state_nx == SUM_START) ||
                   (state_nx == LEN_START);
      rx_enable <= (state_nx == RECV);
    end
  end

  // completed-frame counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= '0;
    end else if (done) begin
      frame_count <= frame_count + 8'd1;
    end
  end

  // sticky overflow flag, only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_frame_checksum.sv
// Directed bench for uart_frame_checksum: three instances cover XOR,
// additive and short-MAX_LEN configurations.
module tb_uart_frame_checksum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data   [3];
  logic       rx_ready  [3];
  logic       tx_busy   [3];
  logic       rx_enable [3];
  logic [7:0] tx_data   [3];
  logic       tx_start  [3];
  logic [7:0] checksum  [3];
  logic [7:0] frame_count [3];
  logic       overflow  [3];
  logic [2:0] state_o   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_frame_checksum u0 (
    .clk(clk), .rst(rst),
    .rx_data(rx_data[0]), .rx_ready(rx_ready[0]),
    .rx_enable(rx_enable[0]), .tx_data(tx_data[0]),
    .tx_start(tx_start[0]), .tx_busy(tx_busy[0]),
    .checksum(checksum[0]), .frame_count(frame_count[0]),
    .overflow(overflow[0]), .state_o(state_o[0])
  );

  uart_frame_checksum #(.MODE(1)) u1 (
    .clk(clk), .rst(rst),
    .rx_data(rx_data[1]), .rx_ready(rx_ready[1]),
    .rx_enable(rx_enable[1]), .tx_data(tx_data[1]),
    .tx_start(tx_start[1]), .tx_busy(tx_busy[1]),
    .checksum(checksum[1]), .frame_count(frame_count[1]),
    .overflow(overflow[1]), .state_o(state_o[1])
  );

  uart_frame_checksum #(.MODE(0), .MAX_LEN(4)) u2 (
    .clk(clk), .rst(rst),
    .rx_data(rx_data[2]), .rx_ready(rx_ready[2]),
    .rx_enable(rx_enable[2]), .tx_data(tx_data[2]),
    .tx_start(tx_start[2]), .tx_busy(tx_busy[2]),
    .checksum(checksum[2]), .frame_count(frame_count[2]),
    .overflow(overflow[2]), .state_o(state_o[2])
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx_char(input int k, input logic [7:0] d);
    rx_data[k]  = d;
    rx_ready[k] = 1'b1;
    @(posedge clk); #1;
    rx_ready[k] = 1'b0;
  endtask

  // called in the tx_start cycle; returns one cycle after busy falls
  task automatic send_word(input int k, input logic [7:0] exp,
                           input int dly, input int hold,
                           input bit inj, input string tag);
    int stray;
    int unstable;
    stray    = 0;
    unstable = 0;
    chk({tag, "_start"}, 32'(tx_start[k]), 32'd1);
    chk({tag, "_data"}, 32'(tx_data[k]), 32'(exp));
    for (int i = 0; i < dly; i++) begin
      if (inj) begin
        rx_data[k]  = 8'h7F;
        rx_ready[k] = 1'b1;
      end
      @(posedge clk); #1;
      if (tx_start[k]) stray++;
      if (tx_data[k] !== exp) unstable++;
    end
    tx_busy[k] = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (inj) begin
        rx_data[k]  = 8'h7F;
        rx_ready[k] = 1'b1;
      end
      @(posedge clk); #1;
      if (tx_start[k]) stray++;
      if (tx_data[k] !== exp) unstable++;
    end
    tx_busy[k]  = 1'b0;
    rx_ready[k] = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_stray"}, 32'(stray), 32'd0);
    chk({tag, "_stable"}, 32'(unstable), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rx_data[k]  = 8'h00;
      rx_ready[k] = 1'b0;
      tx_busy[k]  = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;

    chk("rst_state", 32'(state_o[0]), 32'd0);
    chk("rst_rxen", 32'(rx_enable[0]), 32'd0);
    chk("rst_txst", 32'(tx_start[0]), 32'd0);
    chk("rst_txd", 32'(tx_data[0]), 32'd0);
    chk("rst_sum", 32'(checksum[0]), 32'd0);
    chk("rst_fc", 32'(frame_count[0]), 32'd0);
    chk("rst_ovf", 32'(overflow[2]), 32'd0);

    rst = 1'b0;
    @(posedge clk); #1;
    chk("rxen_up", 32'(rx_enable[0]), 32'd1);

    // XOR frame 41 42 00
    rx_char(0, 8'h41);
    chk("xor_acc1", 32'(checksum[0]), 32'h41);
    rx_char(0, 8'h42);
    chk("xor_acc2", 32'(checksum[0]), 32'h03);
    rx_char(0, 8'h00);
    chk("xor_st1", 32'(state_o[0]), 32'd1);
    chk("xor_rxen0", 32'(rx_enable[0]), 32'd0);
    send_word(0, 8'h03, 1, 2, 1'b0, "xor_sum");
    chk("xor_st4", 32'(state_o[0]), 32'd4);
    send_word(0, 8'h02, 1, 2, 1'b0, "xor_len");
    chk("xor_recv", 32'(state_o[0]), 32'd0);
    chk("xor_rxen1", 32'(rx_enable[0]), 32'd1);
    chk("xor_fc", 32'(frame_count[0]), 32'd1);
    chk("xor_clr", 32'(checksum[0]), 32'd0);

    // additive frame 80 90 00
    rx_char(1, 8'h80);
    chk("add_acc1", 32'(checksum[1]), 32'h80);
    rx_char(1, 8'h90);
    chk("add_acc2", 32'(checksum[1]), 32'h10);
    rx_char(1, 8'h00);
    send_word(1, 8'h10, 2, 3, 1'b0, "add_sum");
    send_word(1, 8'h02, 2, 3, 1'b0, "add_len");
    chk("add_fc", 32'(frame_count[1]), 32'd1);

    // empty frame
    rx_char(0, 8'h00);
    send_word(0, 8'h00, 1, 1, 1'b0, "emp_sum");
    send_word(0, 8'h00, 1, 1, 1'b0, "emp_len");
    chk("emp_fc", 32'(frame_count[0]), 32'd2);

    // overflow with MAX_LEN 4
    rx_char(2, 8'h01);
    rx_char(2, 8'h02);
    rx_char(2, 8'h04);
    rx_char(2, 8'h08);
    chk("ovf_acc", 32'(checksum[2]), 32'h0F);
    chk("ovf_pre", 32'(overflow[2]), 32'd0);
    rx_char(2, 8'h10);
    chk("ovf_set", 32'(overflow[2]), 32'd1);
    chk("ovf_st1", 32'(state_o[2]), 32'd1);
    chk("ovf_drop", 32'(checksum[2]), 32'h0F);
    send_word(2, 8'h0F, 1, 2, 1'b0, "ovf_sum");
    send_word(2, 8'h04, 1, 2, 1'b0, "ovf_len");
    rx_char(2, 8'h03);
    rx_char(2, 8'h00);
    send_word(2, 8'h03, 1, 2, 1'b0, "cln_sum");
    send_word(2, 8'h01, 1, 2, 1'b0, "cln_len");
    chk("ovf_sticky", 32'(overflow[2]), 32'd1);
    chk("cln_fc", 32'(frame_count[2]), 32'd2);

    // late, long busy with rx_ready injected during the send
    rx_char(0, 8'h11);
    rx_char(0, 8'h22);
    rx_char(0, 8'h00);
    send_word(0, 8'h33, 3, 10, 1'b1, "hs_sum");
    send_word(0, 8'h02, 3, 10, 1'b1, "hs_len");
    chk("hs_fc", 32'(frame_count[0]), 32'd3);
    chk("hs_clr", 32'(checksum[0]), 32'd0);
    rx_char(0, 8'h01);
    rx_char(0, 8'h00);
    send_word(0, 8'h01, 1, 1, 1'b0, "hs2_sum");
    send_word(0, 8'h01, 1, 1, 1'b0, "hs2_len");
    chk("hs2_fc", 32'(frame_count[0]), 32'd4);

    // reset asserted during SUM_WAIT_LO
    rx_char(0, 8'h09);
    rx_char(0, 8'h00);
    @(posedge clk); #1;
    tx_busy[0] = 1'b1;
    @(posedge clk); #1;
    chk("mid_st3", 32'(state_o[0]), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid_txst", 32'(tx_start[0]), 32'd0);
    chk("mid_rxen", 32'(rx_enable[0]), 32'd0);
    chk("mid_st0", 32'(state_o[0]), 32'd0);
    chk("mid_fc", 32'(frame_count[0]), 32'd0);
    chk("mid_ovf", 32'(overflow[2]), 32'd0);
    tx_busy[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rxen", 32'(rx_enable[0]), 32'd1);
    rx_char(0, 8'h05);
    chk("post_acc", 32'(checksum[0]), 32'h05);
    rx_char(0, 8'h00);
    send_word(0, 8'h05, 1, 2, 1'b0, "post_sum");
    send_word(0, 8'h01, 1, 2, 1'b0, "post_len");
    chk("post_fc", 32'(frame_count[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
